// File: rtl/sandwich_pkg.sv
// Shared types, widths and dispense ordering for the sandwich sequencing controller.
package sandwich_pkg;

  localparam int DWELL_W  = $clog2(256);
  localparam int NUM_DISP = 4;

  // Encodings are sequential: a dispense state's slot index is (state - ST_BREAD1).
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_BREAD1 = 3'd2,
    ST_HAM    = 3'd3,
    ST_CHEESE = 3'd4,
    ST_BREAD2 = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  typedef struct packed {
    logic b;
    logic h;
    logic s;
  } order_t;

  localparam state_t DISP_ORDER [NUM_DISP] = '{ST_BREAD1, ST_HAM, ST_CHEESE, ST_BREAD2};

  // Bit i enables DISP_ORDER[i]; bread is used for both the first and last slot.
  function automatic logic [NUM_DISP-1:0] slot_enables(input order_t o);
    return {o.b, o.s, o.h, o.b};
  endfunction

  // First enabled dispense state at or after slot 'first', else DONE.
  function automatic state_t next_disp(input logic [NUM_DISP-1:0] en, input int first);
    state_t nxt;
    logic   found;
    nxt   = ST_DONE;
    found = 1'b0;
    for (int i = 0; i < NUM_DISP; i++) begin
      if (!found && i >= first && en[i]) begin
        nxt   = DISP_ORDER[i];
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sandwich_ctrl_if.sv
// Order / validator / dispense / done signal bundle for sandwich_ctrl.
// The abort input exists only when SANDWICH_ABORT_EN is defined.
interface sandwich_ctrl_if #(
  parameter int CNT_W = 8
);

  logic             order_valid;
  logic             order_ready;
  logic             order_b;
  logic             order_h;
  logic             order_s;
  logic             chk_b;
  logic             chk_h;
  logic             chk_s;
  logic             chk_v;
  logic             disp_b;
  logic             disp_h;
  logic             disp_s;
  logic             done_valid;
  logic             done_ok;
  logic             done_ready;
  logic [CNT_W-1:0] sandwich_cnt;
`ifdef SANDWICH_ABORT_EN
  logic             abort;
`endif

  modport slave (
`ifdef SANDWICH_ABORT_EN
    input  abort,
`endif
    input  order_valid, order_b, order_h, order_s, chk_v, done_ready,
    output order_ready, chk_b, chk_h, chk_s, disp_b, disp_h, disp_s,
    output done_valid, done_ok, sandwich_cnt
  );

  modport master (
`ifdef SANDWICH_ABORT_EN
    output abort,
`endif
    output order_valid, order_b, order_h, order_s, chk_v, done_ready,
    input  order_ready, chk_b, chk_h, chk_s, disp_b, disp_h, disp_s,
    input  done_valid, done_ok, sandwich_cnt
  );

endinterface

// File: rtl/sandwich_dwell_timer.sv
// Load/decrement down-counter with zero flag; sets how long each dispense strobe is held.
module sandwich_dwell_timer
  import sandwich_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sandwich_ctrl.sv
// Sequences one order through validation, timed dispense strobes and a done handshake.
// Optional SANDWICH_ABORT_EN adds an abort input that cuts dispensing short with ok=0.
module sandwich_ctrl
  import sandwich_pkg::*;
#(
  parameter int DISP_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  sandwich_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  order_t           order_q;
  logic             ok_q;
  logic [CNT_W-1:0] cnt_q;
  logic             abort_i;
  logic             in_disp;
  logic             dwell_load;
  logic             dwell_zero;

`ifdef SANDWICH_ABORT_EN
  assign abort_i = bus.abort;
`else
  assign abort_i = 1'b0;
`endif

  assign in_disp    = state_q inside {ST_BREAD1, ST_HAM, ST_CHEESE, ST_BREAD2};
  assign dwell_load = (state_d != state_q) &&
                      (state_d inside {ST_BREAD1, ST_HAM, ST_CHEESE, ST_BREAD2});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.order_valid) state_d = ST_CHECK;
      ST_CHECK: state_d = bus.chk_v ? next_disp(slot_enables(order_q), 0) : ST_DONE;
      ST_BREAD1, ST_HAM, ST_CHEESE, ST_BREAD2: begin
        if (abort_i) begin
          state_d = ST_DONE;
        end else if (dwell_zero) begin
          // Slot after the current one is (state - ST_BREAD1 + 1) == state - 1.
          state_d = next_disp(slot_enables(order_q), int'(state_q) - 1);
        end
      end
      ST_DONE:  if (bus.done_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.order_ready = 1'b0;
    bus.chk_b       = 1'b0;
    bus.chk_h       = 1'b0;
    bus.chk_s       = 1'b0;
    bus.disp_b      = 1'b0;
    bus.disp_h      = 1'b0;
    bus.disp_s      = 1'b0;
    bus.done_valid  = 1'b0;
    bus.done_ok     = 1'b0;
    case (state_q)
      ST_IDLE:   bus.order_ready = 1'b1;
      ST_CHECK: begin
        bus.chk_b = order_q.b;
        bus.chk_h = order_q.h;
        bus.chk_s = order_q.s;
      end
      ST_BREAD1, ST_BREAD2: bus.disp_b = 1'b1;
      ST_HAM:    bus.disp_h = 1'b1;
      ST_CHEESE: bus.disp_s = 1'b1;
      ST_DONE: begin
        bus.done_valid = 1'b1;
        bus.done_ok    = ok_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_q <= '0;
      ok_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.order_valid) begin
        order_q <= {bus.order_b, bus.order_h, bus.order_s};
      end
      // Only a dispense sequence that ran out naturally counts as a built sandwich.
      if (state_d == ST_DONE && state_q != ST_DONE) begin
        ok_q <= in_disp && !abort_i;
      end
      if (state_q == ST_DONE && bus.done_ready && ok_q && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.sandwich_cnt = cnt_q;

  sandwich_dwell_timer u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dwell_load),
    .load_val (DWELL_W'(DISP_CYCLES - 1)),
    .dec      (in_disp),
    .zero     (dwell_zero)
  );

endmodule

// File: tb/tb_sandwich_ctrl.sv
// Directed bench for sandwich_ctrl with DISP_CYCLES=3, CNT_W=8.
module tb_sandwich_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tb_v  = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  sandwich_ctrl_if #(.CNT_W(8)) bus ();
  assign bus.chk_v = tb_v;

  sandwich_ctrl #(.DISP_CYCLES(3), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake in the current IDLE cycle; returns in the CHECK cycle with inputs scrambled.
  task automatic send_order(input logic b, input logic h, input logic s);
    bus.order_b     = b;
    bus.order_h     = h;
    bus.order_s     = s;
    bus.order_valid = 1'b1;
    tick();
    bus.order_valid = 1'b0;
    bus.order_b     = ~b;
    bus.order_h     = ~h;
    bus.order_s     = ~s;
  endtask

  task automatic finish_done();
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.order_ready !== 1'b1) begin
      errors++; $display("FAIL reset_order_ready: got %0b expected 1", bus.order_ready);
    end
    checks++;
    if ({bus.chk_b, bus.chk_h, bus.chk_s, bus.disp_b, bus.disp_h, bus.disp_s,
         bus.done_valid, bus.done_ok} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %0h expected 0",
        {bus.chk_b, bus.chk_h, bus.chk_s, bus.disp_b, bus.disp_h, bus.disp_s,
         bus.done_valid, bus.done_ok});
    end
    checks++;
    if (bus.sandwich_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.sandwich_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.order_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready: got %0b expected 1", bus.order_ready);
    end
  endtask

  task automatic test_reset_mid();
    tb_v = 1'b1;
    send_order(1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    checks++;
    if ({bus.disp_b, bus.disp_h, bus.disp_s} !== 3'b010) begin
      errors++; $display("FAIL mid_ham_strobe: got %b expected 010",
        {bus.disp_b, bus.disp_h, bus.disp_s});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.disp_b, bus.disp_h, bus.disp_s, bus.done_valid} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_strobes: got %b expected 0000",
        {bus.disp_b, bus.disp_h, bus.disp_s, bus.done_valid});
    end
    checks++;
    if (bus.order_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset_ready: got %0b expected 1", bus.order_ready);
    end
    checks++;
    if (bus.sandwich_cnt !== 8'(exp_cnt)) begin
      errors++; $display("FAIL mid_reset_cnt: got %0d expected %0d", bus.sandwich_cnt, exp_cnt);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++;
      if ({bus.done_valid, bus.disp_b, bus.disp_h, bus.disp_s, bus.order_ready} !== 5'b00001) begin
        errors++; $display("FAIL post_abort_idle cycle %0d: got %b expected 00001", k,
          {bus.done_valid, bus.disp_b, bus.disp_h, bus.disp_s, bus.order_ready});
      end
    end
  endtask

  task automatic test_full();
    logic [2:0] exp_d;
    tb_v = 1'b1;
    send_order(1'b1, 1'b1, 1'b1);
    checks++;
    if ({bus.chk_b, bus.chk_h, bus.chk_s, bus.disp_b, bus.disp_h, bus.disp_s} !== 6'b111000) begin
      errors++; $display("FAIL full_check: got %b expected 111000",
        {bus.chk_b, bus.chk_h, bus.chk_s, bus.disp_b, bus.disp_h, bus.disp_s});
    end
    for (int k = 2; k <= 13; k++) begin
      tick();
      exp_d = (k <= 4) ? 3'b100 : (k <= 7) ? 3'b010 : (k <= 10) ? 3'b001 : 3'b100;
      checks++;
      if ({bus.disp_b, bus.disp_h, bus.disp_s, bus.done_valid} !== {exp_d, 1'b0}) begin
        errors++; $display("FAIL full_disp T+%0d: got %b expected %b", k,
          {bus.disp_b, bus.disp_h, bus.disp_s, bus.done_valid}, {exp_d, 1'b0});
      end
    end
    tick();
    checks++;
    if ({bus.done_valid, bus.done_ok, bus.disp_b, bus.disp_h, bus.disp_s} !== 5'b11000) begin
      errors++; $display("FAIL full_done T+14: got %b expected 11000",
        {bus.done_valid, bus.done_ok, bus.disp_b, bus.disp_h, bus.disp_s});
    end
    finish_done();
    exp_cnt++;
    checks++;
    if (bus.sandwich_cnt !== 8'(exp_cnt)) begin
      errors++; $display("FAIL full_cnt: got %0d expected %0d", bus.sandwich_cnt, exp_cnt);
    end
    checks++;
    if ({bus.order_ready, bus.done_valid} !== 2'b10) begin
      errors++; $display("FAIL full_back_idle: got %b expected 10", {bus.order_ready, bus.done_valid});
    end
  endtask

  task automatic test_reject();
    bus.done_ready = 1'b1;
    repeat (2) tick();
    bus.done_ready = 1'b0;
    checks++;
    if (bus.sandwich_cnt !== 8'(exp_cnt)) begin
      errors++; $display("FAIL stray_done_ready_cnt: got %0d expected %0d", bus.sandwich_cnt, exp_cnt);
    end
    tb_v = 1'b0;
    send_order(1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.chk_b, bus.chk_h, bus.chk_s} !== 3'b010) begin
      errors++; $display("FAIL reject_check: got %b expected 010", {bus.chk_b, bus.chk_h, bus.chk_s});
    end
    tick();
    checks++;
    if ({bus.done_valid, bus.done_ok, bus.disp_b, bus.disp_h, bus.disp_s} !== 5'b10000) begin
      errors++; $display("FAIL reject_done T+2: got %b expected 10000",
        {bus.done_valid, bus.done_ok, bus.disp_b, bus.disp_h, bus.disp_s});
    end
    finish_done();
    checks++;
    if (bus.sandwich_cnt !== 8'(exp_cnt)) begin
      errors++; $display("FAIL reject_cnt: got %0d expected %0d", bus.sandwich_cnt, exp_cnt);
    end
  endtask

  task automatic test_empty();
    tb_v = 1'b1;
    send_order(1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.done_valid, bus.done_ok, bus.disp_b, bus.disp_h, bus.disp_s} !== 5'b10000) begin
      errors++; $display("FAIL empty_done T+2: got %b expected 10000",
        {bus.done_valid, bus.done_ok, bus.disp_b, bus.disp_h, bus.disp_s});
    end
    finish_done();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_d;
    tb_v = 1'b1;
    send_order(1'b1, 1'b0, 1'b1);
    for (int k = 2; k <= 10; k++) begin
      tick();
      exp_d = (k <= 4) ? 3'b100 : (k <= 7) ? 3'b001 : 3'b100;
      checks++;
      if ({bus.disp_b, bus.disp_h, bus.disp_s} !== exp_d) begin
        errors++; $display("FAIL bs_disp T+%0d: got %b expected %b", k,
          {bus.disp_b, bus.disp_h, bus.disp_s}, exp_d);
      end
    end
    tick();
    checks++;
    if ({bus.done_valid, bus.done_ok} !== 2'b11) begin
      errors++; $display("FAIL bs_done T+11: got %b expected 11", {bus.done_valid, bus.done_ok});
    end
    bus.order_b     = 1'b0;
    bus.order_h     = 1'b0;
    bus.order_s     = 1'b1;
    bus.order_valid = 1'b1;
    tb_v = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({bus.done_valid, bus.done_ok, bus.order_ready} !== 3'b110) begin
        errors++; $display("FAIL stall cycle %0d: got %b expected 110", k,
          {bus.done_valid, bus.done_ok, bus.order_ready});
      end
    end
    finish_done();
    exp_cnt++;
    checks++;
    if ({bus.order_ready, bus.done_valid} !== 2'b10) begin
      errors++; $display("FAIL stall_release: got %b expected 10", {bus.order_ready, bus.done_valid});
    end
    checks++;
    if (bus.sandwich_cnt !== 8'(exp_cnt)) begin
      errors++; $display("FAIL stall_cnt: got %0d expected %0d", bus.sandwich_cnt, exp_cnt);
    end
    tick();
    bus.order_valid = 1'b0;
    checks++;
    if ({bus.chk_b, bus.chk_h, bus.chk_s} !== 3'b001) begin
      errors++; $display("FAIL second_order_check: got %b expected 001", {bus.chk_b, bus.chk_h, bus.chk_s});
    end
    tick();
    checks++;
    if ({bus.done_valid, bus.done_ok} !== 2'b10) begin
      errors++; $display("FAIL second_order_done: got %b expected 10", {bus.done_valid, bus.done_ok});
    end
    finish_done();
  endtask

`ifdef SANDWICH_ABORT_EN
  task automatic test_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if ({bus.order_ready, bus.done_valid} !== 2'b10) begin
      errors++; $display("FAIL abort_idle_ignored: got %b expected 10", {bus.order_ready, bus.done_valid});
    end
    tb_v = 1'b1;
    send_order(1'b1, 1'b1, 1'b1);
    repeat (8) tick();
    checks++;
    if ({bus.disp_b, bus.disp_h, bus.disp_s} !== 3'b001) begin
      errors++; $display("FAIL abort_in_cheese: got %b expected 001", {bus.disp_b, bus.disp_h, bus.disp_s});
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if ({bus.disp_b, bus.disp_h, bus.disp_s, bus.done_valid, bus.done_ok} !== 5'b00010) begin
      errors++; $display("FAIL abort_done: got %b expected 00010",
        {bus.disp_b, bus.disp_h, bus.disp_s, bus.done_valid, bus.done_ok});
    end
    finish_done();
    checks++;
    if (bus.sandwich_cnt !== 8'(exp_cnt)) begin
      errors++; $display("FAIL abort_cnt: got %0d expected %0d", bus.sandwich_cnt, exp_cnt);
    end
  endtask
`endif

  task automatic test_saturate();
    int waited;
    tb_v = 1'b1;
    for (int n = 0; n < 256; n++) begin
      send_order(1'b1, 1'b0, 1'b0);
      waited = 0;
      while (!bus.done_valid && waited < 20) begin
        tick();
        waited++;
      end
      if (n == 0) begin
        checks++;
        if (waited != 7) begin
          errors++; $display("FAIL bread_only_latency: got T+%0d expected T+8", waited + 1);
        end
      end
      checks++;
      if ({bus.done_valid, bus.done_ok} !== 2'b11) begin
        errors++; $display("FAIL sat_done order %0d: got %b expected 11", n, {bus.done_valid, bus.done_ok});
      end
      finish_done();
      if (exp_cnt < 255) exp_cnt++;
      checks++;
      if (bus.sandwich_cnt !== 8'(exp_cnt)) begin
        errors++; $display("FAIL sat_cnt order %0d: got %0d expected %0d", n, bus.sandwich_cnt, exp_cnt);
      end
    end
    checks++;
    if (bus.sandwich_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_final: got %0d expected 255", bus.sandwich_cnt);
    end
  endtask

  initial begin
    bus.order_valid = 1'b0;
    bus.order_b     = 1'b0;
    bus.order_h     = 1'b0;
    bus.order_s     = 1'b0;
    bus.done_ready  = 1'b0;
`ifdef SANDWICH_ABORT_EN
    bus.abort       = 1'b0;
`endif
    test_reset();
    test_reset_mid();
    test_full();
    test_reject();
    test_empty();
    test_back_to_back();
`ifdef SANDWICH_ABORT_EN
    test_abort();
`endif
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sandwich_ctrl.md
Name: sandwich_ctrl

Overview:
Sequencing controller for the combinational `sandwhich` validator (inputs B, H, S; output v).
- Accepts one sandwich order at a time through a valid/ready handshake.
- Presents the latched order to the validator for one cycle and registers v.
- If the order is valid, steps one-hot dispense strobes through bread, ham, cheese and bread, each held for a programmable dwell.
- Reports the result through a done handshake and counts completed sandwiches.

Parameters:
DISP_CYCLES, 3, cycles each dispense strobe is held (legal range 1..255)
CNT_W, 8, width of the completed-sandwich counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
order_valid  in  1  order present
order_ready  out  1  controller can accept an order
order_b  in  1  bread requested
order_h  in  1  ham requested
order_s  in  1  cheese requested
chk_b  out  1  to validator B
chk_h  out  1  to validator H
chk_s  out  1  to validator S
chk_v  in  1  from validator v
disp_b  out  1  bread dispense strobe
disp_h  out  1  ham dispense strobe
disp_s  out  1  cheese dispense strobe
done_valid  out  1  result available
done_ok  out  1  1 = sandwich built, 0 = rejected
done_ready  in  1  consumer accepts result
sandwich_cnt  out  CNT_W  completed-sandwich count

Behaviour:
Reset:
- Reset is asynchronous and active-low on rst_n, with a single clock clk.
- On reset: state IDLE; all outputs 0 except order_ready=1; latched order=0; dwell counter=0.
- Reset asserted mid-operation aborts immediately. No done is reported for the aborted order.

States: IDLE, CHECK, BREAD1, HAM, CHEESE, BREAD2, DONE.

IDLE:
- order_ready=1 only in IDLE.
- Handshake at cycle T when order_valid & order_ready: latch order_b/h/s and go to CHECK.

CHECK:
- Exactly one cycle, at T+1.
- chk_b/h/s = latched order; chk_b/h/s are 0 in every other state.
- chk_v is registered at the end of CHECK.
- If v=1, go to the first enabled dispense state, in the fixed order BREAD1 (if b), HAM (if h), CHEESE (if s), BREAD2 (if b).
- If v=0, or no ingredient is enabled, go to DONE with ok=0.

Dispense states:
- The matching disp_* strobe is high for exactly DISP_CYCLES cycles; the other strobes are low.
- The dwell counter loads DISP_CYCLES-1 on entry and counts down.
- At 0, advance to the next enabled state. After the last enabled state, go to DONE with ok=1.
- Skipped states take zero cycles.
- At most one disp_* is high in any cycle.

DONE:
- done_valid=1 and done_ok is held stable until done_valid & done_ready.
- On that handshake cycle, return to IDLE. order_ready rises in the following cycle.
- done_ready while not done_valid is ignored.

Counter:
- sandwich_cnt increments on each done handshake with ok=1.
- It saturates at 2^CNT_W-1 (no wrap).

Timing:
- Latency from order handshake to done_valid = 2 + DISP_CYCLES × (number of dispense states visited).
- Example: b=1, h=1, s=0, v=1, DISP_CYCLES=3 gives done_valid at T+11.

Other rules:
- order_* input changes after the handshake have no effect.
- The validator is treated as purely combinational. The controller must not sample chk_v in any state other than CHECK.

Optional Feature:
SANDWICH_ABORT_EN:
- Defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in any dispense state deasserts all strobes the next cycle and goes to DONE with ok=0.
  - abort in IDLE, CHECK or DONE is ignored.
  - The counter does not increment on an aborted order.
- Undefined: no abort port; dispense always runs to completion.

Decomposition:
- Package sandwich_pkg holds:
  - the state enum (7 states, 3-bit encoding)
  - localparam DWELL_W = $clog2(256)
  - the dispense-order constant
- One sub-module: sandwich_dwell_timer.
  - Load/decrement/zero-flag counter of width DWELL_W.
  - Instantiated once; drives state advancement.

Test Plan:
1. Reset mid-HAM with DISP_CYCLES=3 (b=1, h=1, s=0), then release → all strobes 0 the same cycle, order_ready=1, sandwich_cnt unchanged, no done_valid.
2. Order b=1, h=1, s=1 with validator v=1 → disp_b at T+2..T+4, disp_h at T+5..T+7, disp_s at T+8..T+10, disp_b at T+11..T+13, done_valid=1 and ok=1 at T+14, sandwich_cnt=1.
3. Order b=0, h=1, s=0 with v=0 → no strobes ever, done_valid at T+2 with ok=0, sandwich_cnt unchanged.
4. done_ready held 0 for 10 cycles in DONE, with a second order_valid pending → done_valid/ok stable, order_ready=0 throughout; the second order is accepted only after the done handshake.
5. Preload the counter near 255 by running 256 valid orders (b=1, h=0, s=0) → sandwich_cnt saturates at 255.
6. SANDWICH_ABORT_EN defined, abort pulsed during CHEESE → strobes low the next cycle, done ok=0, counter unchanged.
